// File: rtl/dual_rail_sequencer_if.sv
// dual_rail_sequencer_if
// Groups every signal that connects the sequencer to its surroundings: the
// upstream valid/ready word port, the dual-rail LUT rails in both directions,
// and the registered result/status port.
//   in_valid, in_data             : upstream word offered to the sequencer
//   in_ready                      : sequencer can accept a word
//   lut_in, lut_inbar             : true/false rails driven into the LUT
//   lut_out, lut_outbar           : true/false rails returned by the LUT
//   res_valid, res_data, res_err  : one-cycle result pulse with status
//   fault                         : sticky error flag
// The slave modport is the sequencer's view. The master modport is the view of
// the environment around it, which includes both the upstream producer and the
// LUT that closes the loop.
interface dual_rail_sequencer_if #(
    parameter int WIDTH     = 256,
    parameter int OUT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [WIDTH-1:0]     lut_in;
    logic [WIDTH-1:0]     lut_inbar;
    logic [OUT_WIDTH-1:0] lut_out;
    logic [OUT_WIDTH-1:0] lut_outbar;
    logic                 res_valid;
    logic [OUT_WIDTH-1:0] res_data;
    logic [1:0]           res_err;
    logic                 fault;

    modport master (
        output in_valid, in_data, lut_out, lut_outbar,
        input  in_ready, lut_in, lut_inbar, res_valid, res_data, res_err, fault
    );

    modport slave (
        input  in_valid, in_data, lut_out, lut_outbar,
        output in_ready, lut_in, lut_inbar, res_valid, res_data, res_err, fault
    );
endinterface

// File: rtl/dual_rail_sequencer.sv
// dual_rail_sequencer
// Drives a combinational dual-rail LUT with a return-to-zero protocol:
// each accepted word is placed on the rails (EVAL), the LUT result is captured
// once every output pair is valid, then the rails return to spacer
// (PRECHARGE) until the LUT outputs are empty again.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave view of dual_rail_sequencer_if (handshake, rails, result)
// res_err encoding: 00 ok, 01 illegal (1,1) pair, 10 evaluate timeout.
module dual_rail_sequencer #(
    parameter int WIDTH       = 256,
    parameter int OUT_WIDTH   = 8,
    parameter int EVAL_CYCLES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dual_rail_sequencer_if.slave    bus
);

    localparam int            CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0] EVAL_LAST = CW'(EVAL_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        PRECHARGE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     lut_in_q;
    logic [WIDTH-1:0]     lut_inbar_q;
    logic                 res_valid_q;
    logic [OUT_WIDTH-1:0] res_data_q;
    logic [1:0]           res_err_q;
    logic                 fault_q;

    logic                 illegal;
    logic                 complete;
    logic                 empty;

    logic                 load_word;
    logic                 clear_rails;
    logic                 cnt_clear;
    logic                 cnt_inc;
    logic                 emit;
    logic [1:0]           emit_err;
    logic [OUT_WIDTH-1:0] emit_data;
    logic                 set_fault;

    // Pair classification of the LUT return rails
    assign illegal  = |(bus.lut_out & bus.lut_outbar);
    assign complete = &(bus.lut_out ^ bus.lut_outbar);
    assign empty    = ~|(bus.lut_out | bus.lut_outbar);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. In EVAL an illegal pair beats a
    // complete result, which in turn beats the timeout, so a result that
    // arrives on the last allowed cycle is still accepted.
    always_comb begin
        state_next  = state;
        load_word   = 1'b0;
        clear_rails = 1'b0;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        emit        = 1'b0;
        emit_err    = 2'b00;
        emit_data   = '0;
        set_fault   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load_word  = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (illegal) begin
                    emit      = 1'b1;
                    emit_err  = 2'b01;
                    set_fault = 1'b1;
                end else if (complete && cnt >= EVAL_LAST) begin
                    emit      = 1'b1;
                    emit_data = bus.lut_out;
                end else if (cnt == TO_LAST) begin
                    emit      = 1'b1;
                    emit_err  = 2'b10;
                    set_fault = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
                if (emit) begin
                    clear_rails = 1'b1;
                    cnt_clear   = 1'b1;
                    state_next  = PRECHARGE;
                end
            end
            PRECHARGE: begin
                if (empty) begin
                    cnt_clear  = 1'b1;
                    state_next = IDLE;
                end else if (cnt == TO_LAST) begin
                    set_fault  = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Rails, cycle counter and result registers. The rails are loaded as an
    // exact complementary pair so the LUT never sees (1,1) or (0,0) while
    // evaluating; res_valid defaults low so it only ever pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_in_q    <= '0;
            lut_inbar_q <= '0;
            cnt         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 2'b00;
            fault_q     <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (load_word) begin
                lut_in_q    <= bus.in_data;
                lut_inbar_q <= ~bus.in_data;
            end else if (clear_rails) begin
                lut_in_q    <= '0;
                lut_inbar_q <= '0;
            end
            if (cnt_clear) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
            if (emit) begin
                res_valid_q <= 1'b1;
                res_data_q  <= emit_data;
                res_err_q   <= emit_err;
            end
            if (set_fault) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.lut_in    = lut_in_q;
    assign bus.lut_inbar = lut_inbar_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_dual_rail_sequencer.sv
// tb_dual_rail_sequencer
// Directed bench for dual_rail_sequencer. A small behavioural LUT model closes
// the loop: in its ideal mode it returns lut_in[7:0] / lut_inbar[7:0], and the
// other modes inject an illegal pair, a stuck spacer bit, or outputs that never
// return to empty. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_dual_rail_sequencer;

    localparam int WIDTH       = 256;
    localparam int OUT_WIDTH   = 8;
    localparam int EVAL_CYCLES = 2;
    localparam int TIMEOUT     = 15;

    logic clk;
    logic rst_n;
    int   lut_mode;
    int   vectors;
    int   miscompares;

    logic [OUT_WIDTH-1:0] model_out;
    logic [OUT_WIDTH-1:0] model_outbar;

    dual_rail_sequencer_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    dual_rail_sequencer #(
        .WIDTH      (WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .EVAL_CYCLES(EVAL_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LUT model: 0 ideal, 1 bit 3 pair (1,1) whenever rails carry data,
    // 2 bit 0 pair stuck at spacer, 3 outputs frozen at a valid non-empty code
    always_comb begin
        model_out    = bus.lut_in[OUT_WIDTH-1:0];
        model_outbar = bus.lut_inbar[OUT_WIDTH-1:0];
        case (lut_mode)
            1: begin
                if ((|bus.lut_in) || (|bus.lut_inbar)) begin
                    model_out[3]    = 1'b1;
                    model_outbar[3] = 1'b1;
                end
            end
            2: begin
                model_out[0]    = 1'b0;
                model_outbar[0] = 1'b0;
            end
            3: begin
                model_out    = 8'h5A;
                model_outbar = 8'hA5;
            end
            default: begin
            end
        endcase
    end

    assign bus.lut_out    = model_out;
    assign bus.lut_outbar = model_outbar;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data);
        bus.in_valid = valid;
        bus.in_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence; E0 in comments is the handshake edge
    initial begin : stimulus
        logic [WIDTH-1:0] word;
        logic             seen_valid;

        vectors     = 0;
        miscompares = 0;
        lut_mode    = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, '0);

        // Reset then idle
        tick();
        tick();
        checkOutput("rst_lut_in", bus.lut_in, '0);
        checkOutput("rst_lut_inbar", bus.lut_inbar, '0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_ready", bus.in_ready, 1);
        checkOutput("idle_res_valid", bus.res_valid, 0);
        checkOutput("idle_fault", bus.fault, 0);
        checkOutput("idle_res_err", bus.res_err, 0);
        checkOutput("idle_res_data", bus.res_data, 0);

        // Single word 10 with the ideal LUT
        $display("[TB] single transfer");
        word = 256'h0A;
        applyStimulus(1'b1, word);
        tick();                                  // E0
        applyStimulus(1'b0, '0);
        checkOutput("e0_lut_in", bus.lut_in, word);
        checkOutput("e0_lut_inbar", bus.lut_inbar, ~word);
        checkOutput("e0_ready", bus.in_ready, 0);
        tick();                                  // E1
        checkOutput("e1_lut_inbar", bus.lut_inbar, ~word);
        checkOutput("e1_res_valid", bus.res_valid, 0);
        tick();                                  // E2
        checkOutput("e2_res_valid", bus.res_valid, 1);
        checkOutput("e2_res_data", bus.res_data, 8'h0A);
        checkOutput("e2_res_err", bus.res_err, 0);
        checkOutput("e2_lut_in", bus.lut_in, '0);
        checkOutput("e2_lut_inbar", bus.lut_inbar, '0);
        checkOutput("e2_ready", bus.in_ready, 0);
        tick();                                  // E3
        checkOutput("e3_res_valid", bus.res_valid, 0);
        checkOutput("e3_ready", bus.in_ready, 1);
        checkOutput("e3_res_data_hold", bus.res_data, 8'h0A);

        // Back-to-back 20 then 255 with in_valid held high
        $display("[TB] back-to-back transfers");
        applyStimulus(1'b1, 256'd20);
        tick();                                  // E0
        applyStimulus(1'b1, 256'd255);
        tick();                                  // E1
        checkOutput("b2b_e1_lut_in", bus.lut_in, 256'd20);
        tick();                                  // E2
        checkOutput("b2b_first_valid", bus.res_valid, 1);
        checkOutput("b2b_first_data", bus.res_data, 8'h14);
        tick();                                  // E3
        checkOutput("b2b_e3_valid", bus.res_valid, 0);
        tick();                                  // E4 second handshake
        applyStimulus(1'b0, '0);
        word = 256'd255;
        checkOutput("b2b_e4_lut_in", bus.lut_in, word);
        checkOutput("b2b_e4_lut_inbar", bus.lut_inbar, ~word);
        tick();                                  // E5
        checkOutput("b2b_e5_valid", bus.res_valid, 0);
        tick();                                  // E6
        checkOutput("b2b_second_valid", bus.res_valid, 1);
        checkOutput("b2b_second_data", bus.res_data, 8'hFF);
        tick();                                  // E7

        // Illegal (1,1) pair on bit 3, then a good transfer keeps fault set
        $display("[TB] illegal pair");
        lut_mode = 1;
        applyStimulus(1'b1, 256'h33);
        tick();                                  // E0
        applyStimulus(1'b0, '0);
        tick();                                  // E1
        checkOutput("ill_valid", bus.res_valid, 1);
        checkOutput("ill_err", bus.res_err, 2'b01);
        checkOutput("ill_data", bus.res_data, 0);
        checkOutput("ill_fault", bus.fault, 1);
        tick();                                  // E2 back to IDLE
        checkOutput("ill_ready", bus.in_ready, 1);
        lut_mode = 0;
        applyStimulus(1'b1, 256'h07);
        tick();
        applyStimulus(1'b0, '0);
        tick();
        tick();
        checkOutput("sticky_data", bus.res_data, 8'h07);
        checkOutput("sticky_err", bus.res_err, 0);
        checkOutput("sticky_fault", bus.fault, 1);
        tick();

        // Reset clears fault, then evaluate timeout with bit 0 stuck at spacer
        $display("[TB] evaluate timeout");
        rst_n = 1'b0;
        #1;
        checkOutput("rst_fault_clear", bus.fault, 0);
        tick();
        rst_n = 1'b1;
        tick();
        lut_mode = 2;
        applyStimulus(1'b1, 256'h0F);
        tick();                                  // E0
        applyStimulus(1'b0, '0);
        seen_valid = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();                              // E1 .. E14
            seen_valid = seen_valid | bus.res_valid;
        end
        checkOutput("to_no_early_valid", seen_valid, 0);
        tick();                                  // E15
        checkOutput("to_valid", bus.res_valid, 1);
        checkOutput("to_err", bus.res_err, 2'b10);
        checkOutput("to_data", bus.res_data, 0);
        checkOutput("to_fault", bus.fault, 1);
        tick();                                  // E16
        checkOutput("to_ready", bus.in_ready, 1);

        // Precharge timeout: LUT outputs never return to empty
        $display("[TB] precharge timeout");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        lut_mode = 3;
        applyStimulus(1'b1, 256'h99);
        tick();                                  // E0
        applyStimulus(1'b0, '0);
        tick();                                  // E1
        tick();                                  // E2
        checkOutput("pc_eval_valid", bus.res_valid, 1);
        checkOutput("pc_eval_data", bus.res_data, 8'h5A);
        seen_valid = 1'b0;
        for (int i = 3; i <= TIMEOUT + 1; i++) begin
            tick();                              // E3 .. E16
            seen_valid = seen_valid | bus.res_valid;
        end
        checkOutput("pc_fault_pending", bus.fault, 0);
        checkOutput("pc_ready_pending", bus.in_ready, 0);
        tick();                                  // E17
        checkOutput("pc_no_valid", seen_valid | bus.res_valid, 0);
        checkOutput("pc_fault", bus.fault, 1);
        checkOutput("pc_ready", bus.in_ready, 1);

        // Reset pulsed mid-EVAL
        $display("[TB] reset mid-evaluate");
        lut_mode = 0;
        tick();
        applyStimulus(1'b1, 256'h42);
        tick();                                  // E0
        applyStimulus(1'b0, '0);
        checkOutput("mid_rails_loaded", bus.lut_in, 256'h42);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_lut_in", bus.lut_in, '0);
        checkOutput("mid_lut_inbar", bus.lut_inbar, '0);
        checkOutput("mid_fault", bus.fault, 0);
        checkOutput("mid_res_valid", bus.res_valid, 0);
        checkOutput("mid_ready", bus.in_ready, 1);
        tick();
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_valid = seen_valid | bus.res_valid;
        end
        checkOutput("mid_no_valid", seen_valid, 0);
        checkOutput("mid_ready_after", bus.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dual_rail_sequencer.md
Name: dual_rail_sequencer

Overview:
- Drives the 256-bit dual-rail LUT circuit (in/inbar -> out/outbar) with a return-to-zero protocol and captures the 8-bit dual-rail result. Each transfer runs precharge, then evaluate, then precharge.
- Upstream side is a single-rail valid/ready word interface. Downstream side is a registered single-rail result with error status.
- Sits directly upstream of the LUT circuit and also consumes its outputs, closing the loop around the combinational dual-rail block.

Parameters:
WIDTH, 256, width of the single-rail input word and of each LUT input rail
OUT_WIDTH, 8, width of each LUT output rail and of res_data
EVAL_CYCLES, 2, minimum evaluate cycles before a result may be accepted (>=1)
TIMEOUT, 15, maximum cycles spent in EVAL or PRECHARGE before error (> EVAL_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream word valid
in_ready  out  1  high when in IDLE; transfer happens on the edge where in_valid & in_ready
in_data  in  WIDTH  single-rail word to evaluate
lut_in  out  WIDTH  true rail to LUT (registered)
lut_inbar  out  WIDTH  false rail to LUT (registered)
lut_out  in  OUT_WIDTH  true rail from LUT
lut_outbar  in  OUT_WIDTH  false rail from LUT
res_valid  out  1  one-cycle pulse, result/status valid
res_data  out  OUT_WIDTH  captured lut_out; 0 on error
res_err  out  2  00 ok, 01 illegal pair (1,1), 10 evaluate timeout
fault  out  1  sticky; set on any error including precharge timeout; cleared only by reset

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; lut_in=lut_inbar=0 (spacer).
  - res_valid=0, res_data=0, res_err=00, fault=0, cycle counter=0.
  - Reset mid-operation aborts the transfer immediately with no result pulse.
- Pair encoding per output bit: (1,0) is 1, (0,1) is 0, (0,0) is spacer, (1,1) is illegal.
  - "complete": every pair is valid, i.e. (lut_out ^ lut_outbar) is all ones and (lut_out & lut_outbar) is 0.
  - "empty": (lut_out | lut_outbar) is 0.
- IDLE:
  - Rails held at spacer; in_ready=1 (decoded from the registered state).
  - On in_valid at a rising edge: latch the word, lut_in<=in_data, lut_inbar<=~in_data, counter<=0, go to EVAL.
- EVAL:
  - Rails hold the data word; counter increments each cycle; LUT returns are sampled every cycle.
  - Priority order, evaluated each edge:
    1. Any illegal pair: res_err<=01, res_data<=0, res_valid<=1, fault<=1, go to PRECHARGE.
    2. complete and counter >= EVAL_CYCLES-1: res_data<=lut_out, res_err<=00, res_valid<=1, go to PRECHARGE.
    3. counter == TIMEOUT-1: res_err<=10, res_data<=0, res_valid<=1, fault<=1, go to PRECHARGE.
  - On every exit to PRECHARGE: rails<=0, counter<=0.
- PRECHARGE:
  - Rails at spacer; in_ready=0.
  - empty: go to IDLE.
  - counter == TIMEOUT-1 without empty: fault<=1, go to IDLE, no res_valid pulse.
- Timing:
  - res_valid is high for exactly one cycle.
  - res_data and res_err hold their values until the next result.
- Nominal timing with EVAL_CYCLES=2 and an ideal combinational LUT, handshake at edge E0:
  - Rails carry data from E0 to E2.
  - res_valid is high E2 to E3.
  - Rails are spacer from E2.
  - in_ready is high from E3.
  - Throughput is one word per 4 cycles.
- in_valid while not in IDLE is ignored; in_data is not sampled.
- The evaluate phase never drives (1,1) or (0,0) on the input rails; lut_inbar == ~lut_in bitwise throughout EVAL.

Test Plan:
- Reset then idle, bench LUT model out=in[7:0] (dual-rail) -> rails 0, in_ready=1, res_valid=0, fault=0.
- in_data=10 with ideal LUT -> res_valid at E2, res_data=8'h0A, res_err=00; rails (0x0A, ~0x0A) during E0..E2, spacer after; in_ready back at E3.
- Back-to-back in_data=20 then 255 with in_valid held high -> two results 8'h14, 8'hFF, spaced exactly 4 cycles apart.
- LUT model forces bit 3 pair to (1,1) during EVAL -> res_err=01, res_data=0, fault=1 (sticky) and stays 1 through later good transfers.
- LUT model holds bit 0 pair at (0,0) forever -> res_valid with res_err=10 exactly TIMEOUT (15) cycles after E0.
- LUT model keeps outputs non-empty after evaluate -> precharge timeout, fault=1, no res_valid.
- rst_n pulsed low mid-EVAL -> outputs immediately return to reset values, no res_valid, in_ready=1 after release.
